// File: rtl/seg7_pkg.sv
// Shared glyph codes, display modes and helpers for the seven-segment scan controller.
package seg7_pkg;

  localparam int unsigned GLYPH_W = 5;

  typedef logic [GLYPH_W-1:0] glyph_t;

  localparam glyph_t GLYPH_F     = 5'd15;
  localparam glyph_t GLYPH_BLANK = 5'd16;
  localparam glyph_t GLYPH_DASH  = 5'd17;

  typedef enum logic [1:0] {
    MODE_STATUS    = 2'd0,
    MODE_COLOR     = 2'd1,
    MODE_FRAME_BIN = 2'd2,
    MODE_FRAME_HEX = 2'd3
  } mode_e;

  // Hex nibble to glyph code.
  function automatic glyph_t nib_glyph(input logic [3:0] nib);
    return glyph_t'(nib);
  endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Glyph code to active-high {g,f,e,d,c,b,a} segment pattern; blank and unknown codes light nothing.
module seg7_glyph_decoder
  import seg7_pkg::*;
(
  input  glyph_t     glyph,
  output logic [6:0] pattern_c
);

  always_comb begin
    pattern_c = 7'h00;
    case (glyph)
      5'd0:       pattern_c = 7'h3F;
      5'd1:       pattern_c = 7'h06;
      5'd2:       pattern_c = 7'h5B;
      5'd3:       pattern_c = 7'h4F;
      5'd4:       pattern_c = 7'h66;
      5'd5:       pattern_c = 7'h6D;
      5'd6:       pattern_c = 7'h7D;
      5'd7:       pattern_c = 7'h07;
      5'd8:       pattern_c = 7'h7F;
      5'd9:       pattern_c = 7'h6F;
      5'd10:      pattern_c = 7'h77;
      5'd11:      pattern_c = 7'h7C;
      5'd12:      pattern_c = 7'h39;
      5'd13:      pattern_c = 7'h5E;
      5'd14:      pattern_c = 7'h79;
      5'd15:      pattern_c = 7'h71;
      GLYPH_DASH: pattern_c = 7'h40;
      default:    pattern_c = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment controller: composes a glyph buffer from status, colour or
// received-frame data, latches it at scan-frame boundaries and drives anode/segment/dot pins.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CH_W         = 24,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [$clog2(N_CH)-1:0]  channel,
  input  logic                     sel_reg,
  input  logic [N_CH*CH_W-1:0]     ch_data,
  input  logic [N_CH*CH_W-1:0]     reg_data,
  input  logic                     fault,
  input  logic                     frame_valid,
  input  logic [7:0]               frame,
  input  logic                     frame_clr,
  output logic [N_DIGITS-1:0]      an,
  output logic [6:0]               seg,
  output logic                     dp,
  output logic                     frame_tick
);

  localparam int unsigned IDX_W    = $clog2(N_DIGITS);
  localparam int unsigned CH_SEL_W = $clog2(N_CH);
  localparam int unsigned PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned NIBBLES  = CH_W / 4;
  localparam logic        INV      = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0]    prescaler;
  logic [IDX_W-1:0]    index;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_phase;
  glyph_t              disp_buf [N_DIGITS];
  logic [N_DIGITS-1:0] disp_dp;
  logic                frame_seen;
  logic [7:0]          frame_q;

  glyph_t              next_buf [N_DIGITS];
  logic [N_DIGITS-1:0] next_dp;
  logic [CH_W-1:0]     word_c;
  glyph_t              ch_glyph_c;
  glyph_t              cur_glyph_c;
  logic [6:0]          pattern_c;
  logic [N_DIGITS-1:0] an_c;
  logic                pre_wrap_c;
  logic                last_digit_c;
  logic                boundary_c;

  assign pre_wrap_c   = (prescaler == PRE_W'(SCAN_DIV - 1));
  assign last_digit_c = (index == IDX_W'(N_DIGITS - 1));
  assign boundary_c   = pre_wrap_c && last_digit_c;
  assign ch_glyph_c   = nib_glyph(4'(channel));

  // Selected channel word; live or registered copy.
  always_comb begin
    word_c = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (channel == CH_SEL_W'(k)) begin
        word_c = sel_reg ? reg_data[k*CH_W +: CH_W] : ch_data[k*CH_W +: CH_W];
      end
    end
  end

  // Next displayed frame, taken up only at a frame boundary.
  always_comb begin
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      next_buf[i] = GLYPH_BLANK;
    end
    next_dp = '0;
    case (mode_e'(mode))
      MODE_STATUS: begin
        next_buf[0] = ch_glyph_c;
        if (fault && blink_phase) begin
          next_buf[N_DIGITS-1] = GLYPH_F;
        end
      end
      MODE_COLOR: begin
        next_buf[0] = ch_glyph_c;
        for (int i = 0; i < int'(NIBBLES); i++) begin
          next_buf[2+i] = nib_glyph(word_c[4*i +: 4]);
        end
        next_dp[2] = sel_reg;
      end
      MODE_FRAME_BIN: begin
        for (int i = 0; i < int'(N_DIGITS); i++) begin
          if (!frame_seen) begin
            next_buf[i] = GLYPH_DASH;
          end else if (i < 8) begin
            next_buf[i] = glyph_t'(frame_q[3'(i)]);
          end
        end
      end
      MODE_FRAME_HEX: begin
        if (frame_seen) begin
          next_buf[0] = nib_glyph(frame_q[3:0]);
          next_buf[1] = nib_glyph(frame_q[7:4]);
        end else begin
          next_buf[0] = GLYPH_DASH;
          next_buf[1] = GLYPH_DASH;
        end
      end
      default: ;
    endcase
  end

  // Digit scan, frame latch and blink timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler   <= '0;
      index       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      disp_dp     <= '0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        disp_buf[i] <= GLYPH_BLANK;
      end
    end else begin
      if (pre_wrap_c) begin
        prescaler <= '0;
        index     <= last_digit_c ? '0 : index + IDX_W'(1);
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
      if (boundary_c) begin
        disp_buf <= next_buf;
        disp_dp  <= next_dp;
        if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
    end
  end

  // Received frame store; a simultaneous valid overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_seen <= 1'b0;
      frame_q    <= '0;
    end else if (frame_valid) begin
      frame_seen <= 1'b1;
      frame_q    <= frame;
    end else if (frame_clr) begin
      frame_seen <= 1'b0;
    end
  end

  assign cur_glyph_c = disp_buf[index];
  assign an_c        = N_DIGITS'(1) << index;

  seg7_glyph_decoder u_decoder (
    .glyph     (cur_glyph_c),
    .pattern_c (pattern_c)
  );

  // Pin drivers with polarity applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= {N_DIGITS{INV}};
      seg        <= {7{INV}};
      dp         <= INV;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_c ^ {N_DIGITS{INV}};
      seg        <= pattern_c ^ {7{INV}};
      dp         <= disp_dp[index] ^ INV;
      frame_tick <= boundary_c;
    end
  end

endmodule
